// File: rtl/reaction_pkg.sv
// Shared constants for the reaction timer: state codes, BCD limits,
// decimal-point patterns and the LFSR feedback taps.
package reaction_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_TIMING = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_EARLY  = 3'd4;
  localparam logic [2:0] ST_TOUT   = 3'd5;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  localparam logic [3:0] DP_OFF    = 4'b0000;
  localparam logic [3:0] DP_NORMAL = 4'b1000;
  localparam logic [3:0] DP_EARLY  = 4'b1111;

  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/bcd_counter4.sv
// Saturating four-digit BCD up-counter holding the round time.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_bcd,
  output logic        o_max
);

  logic [15:0] bcd_q, bcd_d;
  logic        carry;

  // +1 with decimal carry rippling d0 -> d1 -> d2 -> d3
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[i*4 +: 4] == 4'd9) begin
          bcd_d[i*4 +: 4] = 4'd0;
        end else begin
          bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // clear wins over increment; holds at 9999 instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      bcd_q <= '0;
    end else if (i_inc && !o_max) begin
      bcd_q <= bcd_d;
    end
  end

  assign o_max = (bcd_q == BCD_MAX);
  assign o_bcd = bcd_q;

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random pre-stimulus delay, ms timing in BCD,
// first-stop / tie / false-start / timeout detection and best-time tracking.
//
//   state  | meaning
//   IDLE   | after reset, display blank, waiting for start
//   WAIT   | random delay running, stimulus off
//   TIMING | stimulus on, round time counting
//   DONE   | stop seen, time frozen, best time updated
//   EARLY  | stop pressed before the stimulus (false start)
//   TOUT   | nobody stopped before 9.999 s
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int          CLK_FREQ_HZ     = 100_000_000,
  parameter int          N_PLAYERS       = 2,
  parameter int          DELAY_MIN_MS    = 2000,
  parameter int          DELAY_RAND_BITS = 11,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [N_PLAYERS-1:0] i_stop,
  output logic                 o_stimulus,
  output logic [N_PLAYERS-1:0] o_winner,
  output logic [15:0]          o_bcd,
  output logic [3:0]           o_dp,
  output logic [3:0]           o_an_en,
  output logic [15:0]          o_best_bcd,
  output logic                 o_early,
  output logic                 o_timeout,
  output logic [2:0]           o_state
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_clk
    $error("CLK_FREQ_HZ must be at least 1000");
  end
  if (N_PLAYERS < 1 || N_PLAYERS > 8) begin : g_bad_players
    $error("N_PLAYERS must be 1..8");
  end
  if (DELAY_MIN_MS < 1) begin : g_bad_delay_min
    $error("DELAY_MIN_MS must be at least 1");
  end
  if (DELAY_RAND_BITS < 1 || DELAY_RAND_BITS > 15) begin : g_bad_rand_bits
    $error("DELAY_RAND_BITS must be 1..15");
  end
  if (DELAY_MIN_MS + (2 ** DELAY_RAND_BITS) - 1 > 65535) begin : g_bad_delay_fit
    $error("maximum delay does not fit the 16-bit delay counter");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  logic [2:0]           state_q, state_d;
  logic                 start_prev_q, start_re_q;
  logic [N_PLAYERS-1:0] stop_prev_q, stop_re_q;
  logic [15:0]          lfsr_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [15:0]          delay_q, delay_d;
  logic [N_PLAYERS-1:0] winner_q, winner_d;
  logic [15:0]          best_q;

  logic        tick;
  logic        go_wait;
  logic        bcd_clr, bcd_inc, bcd_max;
  logic [15:0] bcd;
  logic [15:0] delay_load;

  assign tick       = (presc_q == PRESC_LAST);
  assign delay_load = 16'(DELAY_MIN_MS) + 16'(lfsr_q[DELAY_RAND_BITS-1:0]);

  bcd_counter4 u_round_time (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (bcd_clr),
    .i_inc   (bcd_inc),
    .o_bcd   (bcd),
    .o_max   (bcd_max)
  );

  // next-state decode; every way into WAIT shares the same round setup
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    winner_d = winner_q;
    bcd_clr  = 1'b0;
    bcd_inc  = 1'b0;
    go_wait  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_re_q) go_wait = 1'b1;
      end
      ST_WAIT: begin
        if (|stop_re_q) begin
          state_d  = ST_EARLY;
          winner_d = stop_re_q;
        end else if (tick) begin
          if (delay_q == 16'd1) state_d = ST_TIMING;
          else                  delay_d = delay_q - 16'd1;
        end
      end
      ST_TIMING: begin
        if (|stop_re_q) begin
          state_d  = ST_DONE;
          winner_d = stop_re_q;
        end else if (tick) begin
          if (bcd_max) state_d = ST_TOUT;
          else         bcd_inc = 1'b1;
        end
      end
      ST_DONE, ST_EARLY, ST_TOUT: begin
        if (start_re_q) go_wait = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_wait) begin
      state_d  = ST_WAIT;
      delay_d  = delay_load;
      winner_d = '0;
      bcd_clr  = 1'b1;
    end
  end

  // edge detectors, LFSR, prescaler, FSM registers and best time
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      start_re_q   <= 1'b0;
      stop_prev_q  <= '0;
      stop_re_q    <= '0;
      lfsr_q       <= LFSR_SEED;
      presc_q      <= '0;
      delay_q      <= '0;
      winner_q     <= '0;
      best_q       <= BCD_MAX;
    end else begin
      start_prev_q <= i_start;
      start_re_q   <= i_start & ~start_prev_q;
      stop_prev_q  <= i_stop;
      stop_re_q    <= i_stop & ~stop_prev_q;
      lfsr_q       <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      if ((state_d != state_q) || tick) presc_q <= '0;
      else                              presc_q <= presc_q + PRESC_W'(1);
      state_q  <= state_d;
      delay_q  <= delay_d;
      winner_q <= winner_d;
      if (state_q == ST_DONE && bcd < best_q) best_q <= bcd;
    end
  end

  // decimal points stay dark together with the digits in IDLE/WAIT
  assign o_an_en    = (state_q == ST_IDLE || state_q == ST_WAIT) ? 4'b0000 : 4'b1111;
  assign o_dp       = (state_q == ST_EARLY) ? DP_EARLY :
                      (o_an_en != 4'b0000)  ? DP_NORMAL : DP_OFF;
  assign o_stimulus = (state_q == ST_TIMING);
  assign o_early    = (state_q == ST_EARLY);
  assign o_timeout  = (state_q == ST_TOUT);
  assign o_state    = state_q;
  assign o_winner   = winner_q;
  assign o_bcd      = bcd;
  assign o_best_bcd = best_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench: dut_a uses the 10-cycle ms tick for rounds, reset and false
// start; dut_b uses a 2-cycle tick so the 9.999 s timeout stays short.
module tb_reaction_timer_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, b_start;
  logic [1:0]  a_stop, b_stop;
  logic        a_stim, b_stim, a_early, b_early, a_tout, b_tout;
  logic [1:0]  a_win, b_win;
  logic [15:0] a_bcd, b_bcd, a_best, b_best;
  logic [3:0]  a_dp, b_dp, a_an, b_an;
  logic [2:0]  a_state, b_state;

  int n_vec = 0;
  int n_bad = 0;

  reaction_timer_multi #(
    .CLK_FREQ_HZ(10_000), .N_PLAYERS(2), .DELAY_MIN_MS(3), .DELAY_RAND_BITS(2), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_stop(a_stop),
    .o_stimulus(a_stim), .o_winner(a_win), .o_bcd(a_bcd), .o_dp(a_dp), .o_an_en(a_an),
    .o_best_bcd(a_best), .o_early(a_early), .o_timeout(a_tout), .o_state(a_state)
  );

  reaction_timer_multi #(
    .CLK_FREQ_HZ(2_000), .N_PLAYERS(2), .DELAY_MIN_MS(3), .DELAY_RAND_BITS(2), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_stop(b_stop),
    .o_stimulus(b_stim), .o_winner(b_win), .o_bcd(b_bcd), .o_dp(b_dp), .o_an_en(b_an),
    .o_best_bcd(b_best), .o_early(b_early), .o_timeout(b_tout), .o_state(b_state)
  );

  typedef struct {
    logic [1:0]  stop;
    logic [15:0] stop_at;
    logic [15:0] exp_bcd;
    logic [1:0]  exp_win;
    logic [15:0] best_entry;
    logic [15:0] best_after;
  } round_t;

  round_t rounds [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_a_bcd(input logic [15:0] v, input int max, input string name);
    int c = 0;
    while (a_bcd !== v && c < max) begin
      @(negedge clk);
      c++;
    end
    chk(name, a_bcd, v);
  endtask

  // pulse start on dut_a and return cycles until the stimulus lights
  task automatic start_round_a(output int cyc);
    a_start = 1'b1;
    cyc = 0;
    @(negedge clk);
    cyc = 1;
    a_start = 1'b0;
    while (!a_stim && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        chk("wait_state", a_state, 3'd1);
        chk("wait_bcd_cleared", a_bcd, 16'h0000);
        chk("wait_winner_cleared", a_win, 2'b00);
        chk("wait_an_off", a_an, 4'b0000);
      end
    end
  endtask

  initial begin
    int cyc;
    int c;
    logic seen;

    rounds[0] = '{stop: 2'b10, stop_at: 16'h0125, exp_bcd: 16'h0125, exp_win: 2'b10,
                  best_entry: 16'h9999, best_after: 16'h0125};
    rounds[1] = '{stop: 2'b01, stop_at: 16'h0200, exp_bcd: 16'h0200, exp_win: 2'b01,
                  best_entry: 16'h0125, best_after: 16'h0125};
    rounds[2] = '{stop: 2'b10, stop_at: 16'h0050, exp_bcd: 16'h0050, exp_win: 2'b10,
                  best_entry: 16'h0125, best_after: 16'h0050};
    rounds[3] = '{stop: 2'b11, stop_at: 16'h0007, exp_bcd: 16'h0007, exp_win: 2'b11,
                  best_entry: 16'h0050, best_after: 16'h0007};

    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_stop = 2'b00; b_stop = 2'b00;
    step(3);
    chk("rst_state", a_state, 3'd0);
    chk("rst_bcd", a_bcd, 16'h0000);
    chk("rst_best", a_best, 16'h9999);
    chk("rst_dp", a_dp, 4'b0000);
    chk("rst_an", a_an, 4'b0000);
    chk("rst_flags", {a_stim, a_early, a_tout, a_win}, 5'b0);
    chk("rst_best_b", b_best, 16'h9999);
    rst = 1'b0;
    step(2);

    // reset in the middle of a timed round
    start_round_a(cyc);
    chk("r0_stim_rise", a_stim, 1'b1);
    wait_a_bcd(16'h0042, 600, "mid_bcd_0042");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", a_state, 3'd0);
    chk("midrst_bcd", a_bcd, 16'h0000);
    chk("midrst_stim", a_stim, 1'b0);
    chk("midrst_best", a_best, 16'h9999);
    chk("midrst_an", a_an, 4'b0000);
    step(2);

    // timed rounds from the table
    for (int r = 0; r < 4; r++) begin
      a_stop = 2'b00;
      start_round_a(cyc);
      chk("delay_in_32_62", 32'(cyc >= 32 && cyc <= 62), 32'd1);
      chk("timing_state", a_state, 3'd2);
      chk("timing_dp", a_dp, 4'b1000);
      chk("timing_an", a_an, 4'b1111);
      wait_a_bcd(rounds[r].stop_at, 2200, "reach_stop_point");
      a_stop = rounds[r].stop;
      @(negedge clk);
      chk("stop_latency_still_timing", a_state, 3'd2);
      @(negedge clk);
      chk("done_state", a_state, 3'd3);
      chk("done_bcd", a_bcd, rounds[r].exp_bcd);
      chk("done_winner", a_win, rounds[r].exp_win);
      chk("best_on_entry", a_best, rounds[r].best_entry);
      chk("done_stim_off", a_stim, 1'b0);
      @(negedge clk);
      chk("best_after", a_best, rounds[r].best_after);
      step(15);
      chk("done_bcd_frozen", a_bcd, rounds[r].exp_bcd);
      chk("done_still", a_state, 3'd3);
      a_stop = 2'b00;
      step(2);
    end

    // false start during WAIT
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    chk("early_pre_wait", a_state, 3'd1);
    step(3);
    a_stop = 2'b01;
    step(2);
    chk("early_state", a_state, 3'd4);
    chk("early_flag", a_early, 1'b1);
    chk("early_dp", a_dp, 4'b1111);
    chk("early_winner", a_win, 2'b01);
    chk("early_an", a_an, 4'b1111);
    a_stop = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (a_stim) seen = 1'b1;
    end
    chk("early_no_stim", seen, 1'b0);
    chk("early_held", a_state, 3'd4);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    chk("early_restart_wait", a_state, 3'd1);
    chk("early_restart_flag", a_early, 1'b0);
    chk("early_restart_winner", a_win, 2'b00);

    // timeout on the fast-tick instance
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (!b_stim && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_delay_in_8_14", 32'(cyc >= 8 && cyc <= 14), 32'd1);
    c = 0;
    while (b_bcd !== 16'h0999 && c < 2500) begin @(negedge clk); c++; end
    chk("b_reach_0999", b_bcd, 16'h0999);
    c = 0;
    while (b_bcd === 16'h0999 && c < 5) begin @(negedge clk); c++; end
    chk("b_carry_1000", b_bcd, 16'h1000);
    c = 0;
    while (b_bcd !== 16'h9999 && c < 20000) begin @(negedge clk); c++; end
    chk("b_reach_9999", b_bcd, 16'h9999);
    chk("b_9999_still_timing", b_state, 3'd2);
    chk("b_9999_no_tout", b_tout, 1'b0);
    c = 0;
    while (b_state !== 3'd5 && c < 6) begin @(negedge clk); c++; end
    chk("b_tout_state", b_state, 3'd5);
    chk("b_tout_flag", b_tout, 1'b1);
    chk("b_tout_bcd", b_bcd, 16'h9999);
    chk("b_tout_stim", b_stim, 1'b0);
    chk("b_tout_dp", b_dp, 4'b1000);
    chk("b_tout_best", b_best, 16'h9999);
    chk("b_tout_winner", b_win, 2'b00);
    step(10);
    chk("b_tout_bcd_hold", b_bcd, 16'h9999);
    chk("b_tout_held", b_state, 3'd5);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    @(negedge clk);
    chk("b_restart_wait", b_state, 3'd1);
    chk("b_restart_bcd", b_bcd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reaction_timer_multi.md
Name: reaction_timer_multi

Overview:
Parametrised next-generation reaction-timer core for N players.
- i_start arms a round with a pseudo-random delay, then lights the stimulus and times each round in milliseconds as 4-digit BCD (X.XXX s).
- Detects the first stop, ties, false starts and timeouts, and tracks the best time.
- Drives the existing seven-segment mux through per-digit BCD, dp-enable and anode-enable outputs.

Parameters:
CLK_FREQ_HZ, 100_000_000, input clock frequency; TICK_DIV = CLK_FREQ_HZ/1000 cycles per ms.
N_PLAYERS, 2, number of stop buttons (1..8).
DELAY_MIN_MS, 2000, fixed part of the pre-stimulus delay.
DELAY_RAND_BITS, 11, random delay part = lfsr[DELAY_RAND_BITS-1:0] ms (0..2047).
LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
i_clk  in  1  single system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  debounced, synchronous level; acts on rising edge
i_stop  in  N_PLAYERS  debounced, synchronous levels; each acts on rising edge
o_stimulus  out  1  stimulus LED, high only in TIMING
o_winner  out  N_PLAYERS  players flagged at the end of a round (ties allowed)
o_bcd  out  16  digits {d3,d2,d1,d0}, d3 = seconds
o_dp  out  4  dp enables; 4'b1000 normally, 4'b1111 in EARLY
o_an_en  out  4  digit enables; 4'b0000 in IDLE/WAIT, else 4'b1111
o_best_bcd  out  16  best valid time since reset
o_early  out  1  high in EARLY
o_timeout  out  1  high in TOUT
o_state  out  3  encoded state, for debug

Behaviour:
- **Reset** (any state, mid-round included): state IDLE; all outputs 0 except o_best_bcd = 16'h9999; LFSR = LFSR_SEED; prescaler and delay counters = 0.
- **Edge detect:** start_re and stop_re[i] = level & ~registered previous level.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11; free-runs every cycle, never cleared except by reset.
- **ms tick:** prescaler counts 0..TICK_DIV-1 and pulses on the wrap. It is cleared on every state entry, so the first tick comes TICK_DIV cycles after entry.
- **States:**
  - IDLE: start_re -> WAIT. On entry to WAIT:
    - delay_cnt loads DELAY_MIN_MS + lfsr[DELAY_RAND_BITS-1:0];
    - o_bcd is cleared;
    - o_winner is cleared.
  - WAIT: delay_cnt decrements on each tick.
    - Any stop_re -> EARLY, with o_winner = stop_re vector. This takes priority over delay expiry in the same cycle.
    - Tick with delay_cnt==1 -> TIMING; o_stimulus rises on the next clock edge.
  - TIMING: o_bcd increments by 1 on each tick, with BCD carry d0->d1->d2->d3.
    - Any stop_re -> DONE, with o_winner = stop_re vector. Simultaneous stops set multiple bits. o_bcd freezes at the current value; a tick in the same cycle is discarded.
    - Tick while o_bcd==16'h9999 -> TOUT; o_bcd holds 9999 (saturates, no wrap).
    - i_start is ignored.
  - DONE: if o_bcd < o_best_bcd (BCD compares as unsigned binary), o_best_bcd updates one cycle after entry.
  - DONE / EARLY / TOUT: start_re -> WAIT, a new round with a fresh delay. Stops are ignored.
- **Outputs:** o_stimulus, o_early and o_timeout are decoded from the registered state; there is no combinational path from input to output.
- **o_state encoding:** IDLE=0, WAIT=1, TIMING=2, DONE=3, EARLY=4, TOUT=5.
- **Latency:** stop edge on the pins -> state/o_winner updated 2 cycles later (1 cycle edge-detect register + 1 cycle state register).
- **Elaboration checks:** DELAY_MIN_MS + 2^DELAY_RAND_BITS - 1 must fit in the 16-bit delay_cnt; DELAY_MIN_MS >= 1.

Decomposition:
- **Package reaction_pkg:**
  - state encodings (the six constants above);
  - BCD_MAX = 16'h9999;
  - DP_NORMAL = 4'b1000, DP_EARLY = 4'b1111;
  - LFSR tap constant.
- **Sub-module bcd_counter4:**
  - ports i_clk, i_reset, i_clr, i_inc;
  - outputs o_bcd[15:0] and o_max;
  - saturating 4-digit BCD incrementer, instantiated once for the round time.
- **Top:** FSM, prescaler, LFSR, edge detectors and best-time register stay in reaction_timer_multi.

Test Plan:
Use sim parameters CLK_FREQ_HZ=10_000 (TICK_DIV=10), DELAY_MIN_MS=3, DELAY_RAND_BITS=2, N_PLAYERS=2.
1. Reset mid-TIMING with o_bcd=0x0042 -> next cycle o_state=0, o_bcd=0, o_stimulus=0, o_best_bcd=0x9999.
2. Start, wait for stimulus, pulse i_stop=2'b10 after 125 ticks -> o_bcd=0x0125, o_winner=2'b10, o_state=3, o_best_bcd=0x0125.
3. Next round, stop at 200 ticks -> o_best_bcd stays 0x0125; third round at 50 ticks -> o_best_bcd=0x0050.
4. i_stop=2'b01 during WAIT -> o_early=1, o_dp=4'b1111, o_winner=2'b01, o_stimulus never rises; i_start -> WAIT again.
5. Both stops on the same edge in TIMING at 7 ticks -> o_winner=2'b11, o_bcd=0x0007.
6. No stop in TIMING -> o_bcd reaches 0x9999, next tick o_timeout=1, o_bcd holds 0x9999; also check that the delay from start to stimulus falls within 3..6 ms (30..60 cycles plus entry latency).
